// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencing one full_adder per clock with a start/done handshake
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx;
  logic [CW-1:0]    cnt;
  logic             carry, fa_s, fa_c, last, accept;
  full_adder u_fa (.a(a_sh[0]), .b(b_sh[0]), .c_in(carry), .s(fa_s), .c_out(fa_c));
  assign busy = state == RUN;
  assign done = state == DONE;
  // next state, acceptance and the partial sum with the new bit entering at the top
  always_comb begin
    acc_nx   = (acc >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    last     = state == RUN && cnt == CW'(WIDTH - 1);
    accept   = state != RUN && start;
    state_nx = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  // operand capture, one bit per cycle in RUN, result registered only on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      c_out <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= b;
        carry <= c_in;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        acc   <= acc_nx;
        carry <= fa_c;
        cnt   <= cnt + CW'(1);
      end
      if (last) begin
        s     <= acc_nx;
        c_out <= fa_c;
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: checks 8-bit and 1-bit instances against a countdown/result model
module tb_serial_add_ctrl;
  logic clk = 0, rst = 1, chk_on = 0;
  logic st8 = 0, ci8 = 0, st1 = 0, a1 = 0, b1 = 0, ci1 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic busy8, done8, c8, busy1, done1, c1;
  logic [7:0] s8;
  logic [0:0] s1;
  int tests = 0, fails = 0;
  int left [2];
  logic [32:0] pend [2], mres [2];
  bit mdone [2];
  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8), .c_in(ci8),
    .busy(busy8), .done(done8), .s(s8), .c_out(c8));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1), .c_in(ci1),
    .busy(busy1), .done(done1), .s(s1), .c_out(c1));

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model: an accepted request yields a+b+c_in after WIDTH cycles of busy, then one done cycle
  initial begin
    for (int i = 0; i < 2; i++) begin left[i] = 0; mdone[i] = 0; mres[i] = 0; pend[i] = 0; end
  end
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        left[i] = 0; mdone[i] = 0; mres[i] = 0;
      end else begin
        mdone[i] = left[i] == 1;
        if (left[i] == 1) mres[i] = pend[i];
        if (left[i] > 0) left[i] = left[i] - 1;
        else if (i == 0 ? st8 : st1) begin
          pend[i] = i == 0 ? 33'(a8) + 33'(b8) + 33'(ci8) : 33'(a1) + 33'(b1) + 33'(ci1);
          left[i] = i == 0 ? 8 : 1;
        end
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("busy8", 33'(busy8), 33'(left[0] > 0));
    chk("done8", 33'(done8), 33'(mdone[0]));
    chk("sum8", 33'({c8, s8}), 33'(mres[0][8:0]));
    chk("busy1", 33'(busy1), 33'(left[1] > 0));
    chk("done1", 33'(done1), 33'(mdone[1]));
    chk("sum1", 33'({c1, s1}), 33'(mres[1][1:0]));
  end

  task automatic step(); @(posedge clk); #1; endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic [8:0] exp);
    int n;
    a8 = a; b8 = b; ci8 = ci; st8 = 1;
    step();
    st8 = 0;
    n = 0;
    do begin step(); n++; end while (!done8 && n < 20);
    chk("lat8", 33'(n), 33'(8));
    chk("res8", 33'({c8, s8}), 33'(exp));
  endtask

  task automatic run1(input logic a, input logic b, input logic ci);
    int n;
    a1 = a; b1 = b; ci1 = ci; st1 = 1;
    step();
    st1 = 0;
    n = 0;
    do begin step(); n++; end while (!done1 && n < 10);
    chk("lat1", 33'(n), 33'(1));
    chk("res1", 33'({c1, s1}), 33'(2'(a) + 2'(b) + 2'(ci)));
  endtask

  logic [16:0] b2b [4] = '{{8'h10, 8'h20, 1'b0}, {8'h80, 8'h80, 1'b1}, {8'h7F, 8'h01, 1'b0}, {8'hC3, 8'h3D, 1'b1}};
  logic [8:0]  b2b_exp [4] = '{9'h030, 9'h101, 9'h080, 9'h101};

  initial begin
    step(); step();
    rst = 0;
    chk_on = 1;
    repeat (4) step();
    chk("idle_busy", 33'(busy8), 33'(0));
    chk("idle_done", 33'(done8), 33'(0));
    chk("idle_sum", 33'({c8, s8}), 33'(0));
    run8(8'h00, 8'h00, 0, 9'h000);
    run8(8'hFF, 8'h01, 0, 9'h100);
    run8(8'hA5, 8'h3C, 1, 9'h0E2);
    run8(8'hFF, 8'hFF, 1, 9'h1FF);
    for (int i = 0; i < 8; i++) run1(i[2], i[1], i[0]);
    a8 = 8'h12; b8 = 8'h34; ci8 = 0; st8 = 1;
    step();
    st8 = 0;
    repeat (3) step();
    a8 = 8'hFF; b8 = 8'hFF; st8 = 1;
    step();
    st8 = 0;
    repeat (3) step();
    chk("intf_done", 33'(done8), 33'(0));
    step();
    chk("intf_done", 33'(done8), 33'(1));
    chk("intf_res", 33'({c8, s8}), 33'(9'h046));
    repeat (10) step();
    a8 = 8'h55; b8 = 8'h66; ci8 = 1; st8 = 1;
    step();
    st8 = 0;
    repeat (4) step();
    rst = 1;
    step();
    rst = 0;
    chk("rst_busy", 33'(busy8), 33'(0));
    chk("rst_sum", 33'({c8, s8}), 33'(0));
    repeat (10) step();
    chk("rst_nodone", 33'(done8), 33'(0));
    run8(8'h01, 8'h01, 0, 9'h002);
    step();
    for (int j = 0; j < 4; j++) begin
      {a8, b8, ci8} = b2b[j]; st8 = 1;
      step();
      if (j == 3) st8 = 0;
      repeat (7) begin step(); chk("b2b_hold", 33'(done8), 33'(0)); end
      step();
      chk("b2b_done", 33'(done8), 33'(1));
      chk("b2b_res", 33'({c8, s8}), 33'(b2b_exp[j]));
    end
    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
